fpu_cvt_w_unit: RTL and testbench

FPU_CVT_W_UNIT -- requirements
Module: fpu_cvt_w_unit

---
 rtl/cpu_defs_pkg.sv | 17 +
 rtl/fpu_float2int.sv | 39 +++
 rtl/fpu_cvt_w_unit.sv | 94 +++++++++
 tb/tb_fpu_cvt_w_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared CPU/FPU types, op codes and constants.
package cpu_defs;
  typedef logic [31:0] Word_t;
  typedef enum logic [2:0] {
    CVT_CVT   = 3'd0,
    CVT_TRUNC = 3'd1,
    CVT_ROUND = 3'd2,
    CVT_CEIL  = 3'd3,
    CVT_FLOOR = 3'd4
  } CvtOp_t;
  typedef enum logic [1:0] {RM_RN, RM_RZ, RM_RP, RM_RM} FpuRm_t;
  localparam Word_t FPU_INT_INVALID = 32'h7FFFFFFF;
  function automatic CvtOp_t cvt_resolve(input logic [2:0] op, input FpuRm_t rm);
    if (op != 3'd0) return CvtOp_t'(op);
    return rm == RM_RN ? CVT_ROUND : rm == RM_RZ ? CVT_TRUNC : rm == RM_RP ? CVT_CEIL : CVT_FLOOR;
  endfunction
endpackage

// File: rtl/fpu_float2int.sv
// fpu_float2int: combinational single-precision to signed 32-bit integer conversion.
module fpu_float2int
  import cpu_defs::*;
(
  input  CvtOp_t op_i,
  input  Word_t  src_i,
  output Word_t  res_o,
  output logic   invalid_o
);
  logic        sgn, g, st, inc, big, zero, tiny;
  logic [7:0]  e;
  logic [22:0] f;
  logic [4:0]  k;
  logic [55:0] w;
  logic [31:0] ip;
  logic [32:0] mag, lim;
  always_comb begin
    sgn  = src_i[31];
    e    = src_i[30:23];
    f    = src_i[22:0];
    zero = e == 8'd0;
    tiny = e < 8'd126;
    big  = e >= 8'd158;
    // mantissa shifted so bits [55:24] are the integer part and [23:0] the fraction
    k    = 5'(e - 8'd126);
    w    = 56'({1'b1, f}) << k;
    ip   = tiny ? 32'd0 : w[55:24];
    g    = tiny ? 1'b0 : w[23];
    st   = tiny ? 1'b1 : |w[22:0];
    inc  = zero ? 1'b0 :
           op_i == CVT_ROUND ? g :
           op_i == CVT_CEIL  ? !sgn && (g || st) :
           op_i == CVT_FLOOR ? sgn && (g || st) : 1'b0;
    mag  = big ? 33'h080000000 : {1'b0, ip} + 33'(inc);
    lim  = sgn ? 33'h080000000 : 33'h07FFFFFFF;
    invalid_o = e == 8'hFF || (big && (e != 8'd158 || f != 23'd0)) || mag > lim;
    res_o = zero ? 32'd0 : invalid_o ? FPU_INT_INVALID : sgn ? -mag[31:0] : mag[31:0];
  end
endmodule

// File: rtl/fpu_cvt_w_unit.sv
// fpu_cvt_w_unit: two-stage float-to-word conversion pipeline with sticky flags.
module fpu_cvt_w_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_rm,
  input  logic [31:0] req_src,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_invalid,
  output logic        resp_inexact,
  output logic [1:0]  flags,
  input  logic        flags_clr
);
  logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [2:0]  s1_op_q, s1_op_d;
  FpuRm_t      s1_rm_q, s1_rm_d;
  Word_t       s1_src_q, s1_src_d;
  Word_t       s2_data_q, s2_data_d;
  logic        s2_inv_q, s2_inv_d, s2_inx_q, s2_inx_d;
  logic [1:0]  flags_q, flags_d;
  logic        s1_adv, s2_adv, rsv, cvt_inv, frac_nz;
  logic [7:0]  e;
  logic [22:0] f;
  logic [4:0]  sh;
  Word_t       cvt_res;
  CvtOp_t      op_eff;

  assign op_eff = cvt_resolve(s1_op_q, s1_rm_q);

  fpu_float2int u_f2i (
    .op_i      (op_eff),
    .src_i     (s1_src_q),
    .res_o     (cvt_res),
    .invalid_o (cvt_inv)
  );

  always_comb begin
    s2_adv = !s2_valid_q || resp_ready;
    s1_adv = !s1_valid_q || s2_adv;
    e      = s1_src_q[30:23];
    f      = s1_src_q[22:0];
    sh     = 5'(8'd150 - e);
    // fraction bits below the binary point: all of them under 1.0, none from 2^23 up
    frac_nz = e == 8'd0 ? |f : e < 8'd127 ? 1'b1 : e < 8'd150 ? |(f & ~(23'h7FFFFF << sh)) : 1'b0;
    rsv        = s1_op_q > 3'd4;
    s1_valid_d = flush ? 1'b0 : s1_adv ? req_valid : s1_valid_q;
    s2_valid_d = flush ? 1'b0 : s2_adv ? s1_valid_q : s2_valid_q;
    s1_op_d    = s1_adv && req_valid ? req_op : s1_op_q;
    s1_rm_d    = s1_adv && req_valid ? FpuRm_t'(req_rm) : s1_rm_q;
    s1_src_d   = s1_adv && req_valid ? req_src : s1_src_q;
    s2_data_d  = s2_adv && s1_valid_q ? (rsv ? 32'd0 : cvt_res) : s2_data_q;
    s2_inv_d   = s2_adv && s1_valid_q ? !rsv && cvt_inv : s2_inv_q;
    s2_inx_d   = s2_adv && s1_valid_q ? !rsv && !cvt_inv && frac_nz : s2_inx_q;
    flags_d    = flags_clr ? 2'b00 : resp_valid && resp_ready ? flags_q | {s2_inv_q, s2_inx_q} : flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_op_q    <= 3'd0;
      s1_rm_q    <= RM_RN;
      s1_src_q   <= '0;
      s2_data_q  <= '0;
      s2_inv_q   <= 1'b0;
      s2_inx_q   <= 1'b0;
      flags_q    <= 2'b00;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rm_q    <= s1_rm_d;
      s1_src_q   <= s1_src_d;
      s2_data_q  <= s2_data_d;
      s2_inv_q   <= s2_inv_d;
      s2_inx_q   <= s2_inx_d;
      flags_q    <= flags_d;
    end
  end

  assign req_ready    = s1_adv;
  assign resp_valid   = s2_valid_q;
  assign resp_data    = s2_data_q;
  assign resp_invalid = s2_inv_q;
  assign resp_inexact = s2_inx_q;
  assign flags        = flags_q;
endmodule

// File: tb/tb_fpu_cvt_w_unit.sv
// tb_fpu_cvt_w_unit: directed scoreboard bench for the float-to-word pipeline.
module tb_fpu_cvt_w_unit;
  logic        clk = 1'b0, rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_rm, flags;
  logic [31:0] req_src, resp_data;
  logic        resp_invalid, resp_inexact, flags_clr;
  typedef struct packed {logic [31:0] d; logic inv; logic inx;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, n_resp = 0, base;

  fpu_cvt_w_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rm(req_rm), .req_src(req_src), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_invalid(resp_invalid),
    .resp_inexact(resp_inexact), .flags(flags), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 64'(sb.size()), 64'd1);
      else begin
        chk(resp_ready ? "resp" : "hold", 64'({resp_data, resp_invalid, resp_inexact}), 64'(sb[0]));
        if (resp_ready) begin
          void'(sb.pop_front());
          n_resp++;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] src,
                      input logic [31:0] d, input logic inv, input logic inx);
    int t = 0;
    req_op = op; req_rm = rm; req_src = src; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    else sb.push_back({d, inv, inx});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rm = 2'd0; req_src = '0;
    resp_ready = 1'b1; flags_clr = 1'b0;
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_resp", 64'({resp_data, resp_invalid, resp_inexact}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    // latency: ROUND 2.5
    req_op = 3'd2; req_rm = 2'd0; req_src = 32'h40200000; req_valid = 1'b1;
    sb.push_back({32'd3, 1'b0, 1'b1});
    @(negedge clk);
    chk("lat_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(resp_valid), 64'd1);
    @(posedge clk);
    #1;
    send(3'd4, 2'd0, 32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1);
    send(3'd3, 2'd0, 32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1);
    send(3'd0, 2'd1, 32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1);
    send(3'd2, 2'd0, 32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1);
    send(3'd0, 2'd0, 32'h40200000, 32'd3, 1'b0, 1'b1);
    send(3'd0, 2'd2, 32'h40200000, 32'd3, 1'b0, 1'b1);
    send(3'd0, 2'd3, 32'h40200000, 32'd2, 1'b0, 1'b1);
    drain();
    chk("flags_inexact", 64'(flags), 64'd1);
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    chk("flags_clr", 64'(flags), 64'd0);
    send(3'd1, 2'd0, 32'h4F32D05E, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(3'd1, 2'd0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0);
    drain();
    chk("flags_invalid", 64'(flags), 64'd2);
    for (int i = 0; i < 5; i++) send(3'(i), 2'd0, 32'h3F800000, 32'd1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) send(3'd0, 2'(i), 32'h3F800000, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(3'(i), 2'd2, 32'h00000001, 32'd0, 1'b0, 1'b1);
    send(3'd4, 2'd0, 32'h80000001, 32'd0, 1'b0, 1'b1);
    send(3'd2, 2'd0, 32'h3F000000, 32'd1, 1'b0, 1'b1);
    send(3'd4, 2'd0, 32'h3F000000, 32'd0, 1'b0, 1'b1);
    send(3'd3, 2'd0, 32'hBF000000, 32'd0, 1'b0, 1'b1);
    send(3'd2, 2'd0, 32'hBF000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    send(3'd1, 2'd0, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0);
    send(3'd1, 2'd0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0);
    send(3'd1, 2'd0, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(3'd4, 2'd0, 32'hFF800000, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(3'd5, 2'd0, 32'h40200000, 32'd0, 1'b0, 1'b0);
    send(3'd7, 2'd0, 32'h7FC00000, 32'd0, 1'b0, 1'b0);
    drain();
    // back-to-back with a stalled consumer
    base = n_resp;
    resp_ready = 1'b0;
    send(3'd1, 2'd0, 32'h3F800000, 32'd1, 1'b0, 1'b0);
    send(3'd2, 2'd0, 32'h40200000, 32'd3, 1'b0, 1'b1);
    req_op = 3'd4; req_src = 32'hBFC00000; req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_full_ready", 64'(req_ready), 64'd0);
    chk("b2b_full_valid", 64'(resp_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("b2b_still_full", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    send(3'd4, 2'd0, 32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1);
    send(3'd3, 2'd0, 32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1);
    drain();
    chk("b2b_count", 64'(n_resp - base), 64'd4);
    // flush with both stages full and a simultaneous request
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    send(3'd2, 2'd0, 32'h3F000000, 32'd1, 1'b0, 1'b1);
    drain();
    chk("pre_flush_flags", 64'(flags), 64'd1);
    resp_ready = 1'b0;
    send(3'd1, 2'd0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(3'd3, 2'd0, 32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1);
    req_op = 3'd1; req_src = 32'h4F32D05E; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    sb.delete();
    chk("flush_valid", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_no_late", 64'(resp_valid), 64'd0);
    chk("flush_flags", 64'(flags), 64'd1);
    @(posedge clk);
    #1;
    send(3'd1, 2'd0, 32'hCF000000, 32'h80000000, 1'b0, 1'b0);
    drain();
    chk("post_flush_flags", 64'(flags), 64'd1);
    // reset mid-flight
    send(3'd2, 2'd0, 32'h40200000, 32'd3, 1'b0, 1'b1);
    send(3'd1, 2'd0, 32'h3F800000, 32'd1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_flags", 64'(flags), 64'd0);
    chk("midrst_data", 64'(resp_data), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_no_resp", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    send(3'd0, 2'd0, 32'h3F800000, 32'd1, 1'b0, 1'b0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
